seg595_scan_driver: RTL and testbench

//  Parametrised multiplexed 7-segment driver over a 74HC595 chain: 16 bits per digit
//   (8 segment bits, then 8 digit-select bits).

---
 rtl/seg595_pkg.sv | 36 +++
 rtl/bin2bcd_seq.sv | 60 ++++++
 rtl/seg595_scan_driver.sv | 240 ++++++++++++++++++++++++
 tb/tb_seg595_scan_driver.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg595_pkg.sv
// rtl/seg595_pkg.sv - shared constants, segment codes and scan states for the 595 display driver
package seg595_pkg;

    localparam int WORD_W = 16;

    // Segment bytes are {dp,g,f,e,d,c,b,a}, active-high before any inversion
    localparam logic [7:0] SEG_MINUS = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef enum logic [2:0] {
        S_BUILD,
        S_SH_LO,
        S_SH_HI,
        S_LATCH,
        S_HOLD
    } scan_state_t;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] r;
        case (d)
            4'd0:    r = 8'h3F;
            4'd1:    r = 8'h06;
            4'd2:    r = 8'h5B;
            4'd3:    r = 8'h4F;
            4'd4:    r = 8'h66;
            4'd5:    r = 8'h6D;
            4'd6:    r = 8'h7D;
            4'd7:    r = 8'h07;
            4'd8:    r = 8'h7F;
            4'd9:    r = 8'h6F;
            default: r = SEG_BLANK;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble converter, one bit per clock
module bin2bcd_seq #(
    parameter int DATA_W     = 20,
    parameter int NUM_DIGITS = 6
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [DATA_W-1:0]       bin,
    output logic                    last,
    output logic [NUM_DIGITS*4-1:0] bcd,
    output logic                    ovf
);

    // Enough digits to hold any DATA_W value, plus one spare so the
    // "above the displayed digits" slice is never empty.
    localparam int FIT_D  = (DATA_W + 2) / 3;
    localparam int FULL_D = ((FIT_D > NUM_DIGITS) ? FIT_D : NUM_DIGITS) + 1;
    localparam int CNT_W  = $clog2(DATA_W + 1);

    logic [FULL_D*4-1:0] acc;
    logic [FULL_D*4-1:0] acc_adj;
    logic [DATA_W-1:0]   sh;
    logic [CNT_W-1:0]    cnt;
    logic                busy;

    // Add-3 correction on every BCD digit that is 5 or more before the shift
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < FULL_D; i++) begin
            if (acc[i*4 +: 4] >= 4'd5) begin
                acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Load on start, then shift one binary bit into the BCD accumulator per cycle
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy <= 1'b0;
            cnt  <= '0;
            acc  <= '0;
            sh   <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CNT_W'(DATA_W);
            acc  <= '0;
            sh   <= bin;
        end else if (busy) begin
            {acc, sh} <= {acc_adj[FULL_D*4-2:0], sh, 1'b0};
            cnt       <= cnt - 1'b1;
            busy      <= (cnt != CNT_W'(1));
        end
    end

    assign last = busy && (cnt == CNT_W'(1));
    assign bcd  = acc[NUM_DIGITS*4-1:0];
    assign ovf  = |acc[FULL_D*4-1:NUM_DIGITS*4];

endmodule

// File: rtl/seg595_scan_driver.sv
// rtl/seg595_scan_driver.sv - multiplexed 7-segment driver over a 74HC595 chain with BCD load and PWM
module seg595_scan_driver
    import seg595_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int DATA_W     = 20,
    parameter int CLK_DIV    = 4,
    parameter int SCAN_HOLD  = 256,
    parameter int BRIGHT_W   = 4,
    parameter int SEG_INV    = 1,
    parameter int SEL_INV    = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_W-1:0]     data_bin,
    input  logic                  neg,
    input  logic [NUM_DIGITS-1:0] dot,
    input  logic                  load,
    output logic                  ready,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic                  ovf,
    output logic                  ds,
    output logic                  shcp,
    output logic                  stcp,
    output logic                  roe
);

    localparam int         NBCD     = NUM_DIGITS * 4;
    localparam int         DIV_W    = $clog2(CLK_DIV + 1);
    localparam int         HC_W     = $clog2(SCAN_HOLD + 1);
    localparam logic [7:0] SEG_MASK = (SEG_INV != 0) ? 8'hFF : 8'h00;
    localparam logic [7:0] SEL_MASK = (SEL_INV != 0) ? 8'hFF : 8'h00;

    logic                  accept;
    logic                  conv_last;
    logic                  conv_ovf;
    logic [NBCD-1:0]       conv_bcd;

    logic                  pend_valid;
    logic                  pend_neg;
    logic [NUM_DIGITS-1:0] pend_dot;

    logic [NBCD-1:0]       disp_bcd;
    logic                  disp_neg;
    logic [NUM_DIGITS-1:0] disp_dot;

    scan_state_t           state;
    logic [2:0]            dig;
    logic [DIV_W-1:0]      div_cnt;
    logic [3:0]            bit_cnt;
    logic [WORD_W-1:0]     sh_word;
    logic [HC_W-1:0]       hold_cnt;
    logic [HC_W-1:0]       on_cycles;
    logic [HC_W-1:0]       on_calc;

    logic                  wrap;
    logic                  commit;
    logic                  commit_ovf;

    logic [2:0]            msd;
    logic                  any_nz;
    logic [3:0]            cur_d;
    logic                  cur_dot;
    logic [2:0]            minus_pos;
    logic [7:0]            seg_act;
    logic [7:0]            sel_act;
    logic [WORD_W-1:0]     word;

    assign accept = load & ready;

    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bcd (
        .clk   (clk),
        .rstn  (rstn),
        .start (accept),
        .bin   (data_bin),
        .last  (conv_last),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    // A frame wraps when the last digit's hold ends; new data is only taken there
    assign wrap       = (state == S_HOLD) && (hold_cnt == HC_W'(SCAN_HOLD - 1))
                        && (dig == 3'(NUM_DIGITS - 1));
    assign commit     = wrap && pend_valid;
    // Negative values lose the top digit to the minus sign
    assign commit_ovf = conv_ovf || (pend_neg && (conv_bcd[NBCD-1 -: 4] != 4'd0));

    assign on_calc    = HC_W'((32'(bright) * 32'(SCAN_HOLD)) >> BRIGHT_W);

    // Handshake: capture sign/dots on accept, hold the result pending until the frame wraps
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ready      <= 1'b1;
            pend_valid <= 1'b0;
            pend_neg   <= 1'b0;
            pend_dot   <= '0;
        end else if (accept) begin
            ready      <= 1'b0;
            pend_valid <= 1'b0;
            pend_neg   <= neg;
            pend_dot   <= dot;
        end else if (conv_last) begin
            ready      <= 1'b1;
            pend_valid <= 1'b1;
        end else if (commit) begin
            pend_valid <= 1'b0;
        end
    end

    // Display registers change only at frame start so a frame never mixes two values
    always_ff @(posedge clk) begin
        if (!rstn) begin
            disp_bcd <= '0;
            disp_neg <= 1'b0;
            disp_dot <= '0;
            ovf      <= 1'b0;
        end else if (commit) begin
            disp_bcd <= conv_bcd;
            disp_neg <= pend_neg;
            disp_dot <= pend_dot;
            ovf      <= commit_ovf;
        end
    end

    // Segment and select bytes for the digit currently being scanned
    always_comb begin
        msd     = '0;
        any_nz  = 1'b0;
        cur_d   = '0;
        cur_dot = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (disp_bcd[i*4 +: 4] != 4'd0) begin
                msd    = 3'(i);
                any_nz = 1'b1;
            end
            if (3'(i) == dig) begin
                cur_d   = disp_bcd[i*4 +: 4];
                cur_dot = disp_dot[i];
            end
        end
        minus_pos = blank_lz ? (msd + 3'd1) : 3'(NUM_DIGITS - 1);
        if (ovf) begin
            seg_act = SEG_MINUS;
        end else if (disp_neg && any_nz && (dig == minus_pos)) begin
            seg_act = SEG_MINUS;
        end else if (blank_lz && (dig > msd)) begin
            seg_act = SEG_BLANK;
        end else begin
            seg_act = seg_code(cur_d);
        end
        seg_act[7] = seg_act[7] | cur_dot;
        sel_act    = 8'b1 << dig;
        word       = {seg_act ^ SEG_MASK, sel_act ^ SEL_MASK};
    end

    // Scan FSM: build word, shift 16 bits MSB first, latch, then hold with PWM on roe
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_BUILD;
            dig       <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            sh_word   <= '0;
            hold_cnt  <= '0;
            on_cycles <= '0;
            ds        <= 1'b0;
            shcp      <= 1'b0;
            stcp      <= 1'b0;
            roe       <= 1'b1;
        end else begin
            case (state)
                S_BUILD: begin
                    ds      <= word[WORD_W-1];
                    sh_word <= {word[WORD_W-2:0], 1'b0};
                    shcp    <= 1'b0;
                    roe     <= 1'b1;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    state   <= S_SH_LO;
                end
                S_SH_LO: begin
                    if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        shcp    <= 1'b1;
                        state   <= S_SH_HI;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_SH_HI: begin
                    if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        shcp    <= 1'b0;
                        if (bit_cnt == 4'(WORD_W - 1)) begin
                            stcp  <= 1'b1;
                            state <= S_LATCH;
                        end else begin
                            ds      <= sh_word[WORD_W-1];
                            sh_word <= {sh_word[WORD_W-2:0], 1'b0};
                            bit_cnt <= bit_cnt + 1'b1;
                            state   <= S_SH_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_LATCH: begin
                    if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                        div_cnt   <= '0;
                        stcp      <= 1'b0;
                        hold_cnt  <= '0;
                        on_cycles <= on_calc;
                        roe       <= (on_calc == '0);
                        state     <= S_HOLD;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HC_W'(SCAN_HOLD - 1)) begin
                        roe   <= 1'b1;
                        dig   <= (dig == 3'(NUM_DIGITS - 1)) ? 3'd0 : dig + 3'd1;
                        state <= S_BUILD;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                        roe      <= !((hold_cnt + 1'b1) < on_cycles);
                    end
                end
                default: begin
                    state <= S_BUILD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg595_scan_driver.sv
// tb/tb_seg595_scan_driver.sv - randomized self-checking bench for seg595_scan_driver
module tb_seg595_scan_driver;

    localparam int NUM_DIGITS = 6;
    localparam int DATA_W     = 20;
    localparam int CLK_DIV    = 2;
    localparam int SCAN_HOLD  = 64;
    localparam int BRIGHT_W   = 4;

    localparam logic [7:0] SEGS [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                         8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic [DATA_W-1:0]     data_bin = '0;
    logic                  neg = 1'b0;
    logic [NUM_DIGITS-1:0] dot = '0;
    logic                  load = 1'b0;
    logic                  ready;
    logic                  blank_lz = 1'b1;
    logic [BRIGHT_W-1:0]   bright = '1;
    logic                  ovf;
    logic                  ds;
    logic                  shcp;
    logic                  stcp;
    logic                  roe;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seg595_scan_driver #(
        .NUM_DIGITS (NUM_DIGITS),
        .DATA_W     (DATA_W),
        .CLK_DIV    (CLK_DIV),
        .SCAN_HOLD  (SCAN_HOLD),
        .BRIGHT_W   (BRIGHT_W),
        .SEG_INV    (1),
        .SEL_INV    (0)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .data_bin (data_bin),
        .neg      (neg),
        .dot      (dot),
        .load     (load),
        .ready    (ready),
        .blank_lz (blank_lz),
        .bright   (bright),
        .ovf      (ovf),
        .ds       (ds),
        .shcp     (shcp),
        .stcp     (stcp),
        .roe      (roe)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pin-level 595 monitor: rebuilds every latched word and measures roe low time
    logic [15:0] mon_sr = '0;
    logic        prev_shcp = 1'b0;
    logic        prev_stcp = 1'b0;
    logic        prev_ds = 1'b0;
    int          sh_bits = 0;
    int          frame_cnt = 0;
    int          latch_cnt = 0;
    int          proto_err = 0;
    int          low_cnt = 0;
    int          last_low = 0;
    logic [7:0]  lat_seg [NUM_DIGITS];

    always @(negedge clk) begin : monitor
        logic [7:0] sel;
        int k;
        int ones;
        if (!rstn) begin
            sh_bits = 0;
            low_cnt = 0;
        end else begin
            if (shcp && !prev_shcp) begin
                mon_sr = {mon_sr[14:0], ds};
                sh_bits++;
            end
            if (shcp && prev_shcp && (ds !== prev_ds)) proto_err++;
            if (!roe && (shcp || stcp)) proto_err++;
            if (!roe) low_cnt++;
            if (stcp && !prev_stcp) begin
                sel  = mon_sr[7:0];
                ones = 0;
                k    = 0;
                for (int i = 0; i < 8; i++) begin
                    if (sel[i]) begin
                        ones++;
                        k = i;
                    end
                end
                if (ones != 1 || k >= NUM_DIGITS) begin
                    proto_err++;
                end else begin
                    lat_seg[k] = ~mon_sr[15:8];
                    if (k == 0) frame_cnt++;
                end
                last_low = low_cnt;
                low_cnt  = 0;
                latch_cnt++;
                sh_bits  = 0;
            end
        end
        prev_shcp = shcp;
        prev_stcp = stcp;
        prev_ds   = ds;
    end

    function automatic longint pow10(input int n);
        longint p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic bit exp_ovf(input longint v, input bit ng);
        longint limit;
        limit = (ng && v != 0) ? pow10(NUM_DIGITS - 1) - 1 : pow10(NUM_DIGITS) - 1;
        return (v > limit);
    endfunction

    // What a human would read on digit k, as an active-high segment byte
    function automatic logic [7:0] exp_seg(input int k, input longint v, input bit ng,
                                           input logic [NUM_DIGITS-1:0] dt, input bit blz);
        logic [7:0] r;
        int nd;
        int mpos;
        longint t;
        int dk;
        if (exp_ovf(v, ng)) begin
            r = 8'h40;
        end else begin
            nd = 1;
            t  = v / 10;
            while (t > 0) begin
                nd++;
                t = t / 10;
            end
            dk   = int'((v / pow10(k)) % 10);
            mpos = blz ? nd : NUM_DIGITS - 1;
            if (ng && v != 0 && k == mpos) r = 8'h40;
            else if (blz && k >= nd) r = 8'h00;
            else r = SEGS[dk];
        end
        if (dt[k]) r[7] = 1'b1;
        return r;
    endfunction

    task automatic wait_ready();
        int c = 0;
        while (!ready && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (!ready) check("ready_timeout", ready, 1);
    endtask

    task automatic wait_frames(input int n);
        int s = frame_cnt;
        int c = 0;
        while (frame_cnt < s + n && c < 20000) begin
            @(negedge clk);
            c++;
        end
        if (frame_cnt < s + n) check("frame_timeout", frame_cnt, s + n);
    endtask

    task automatic wait_latches(input int n);
        int s = latch_cnt;
        int c = 0;
        while (latch_cnt < s + n && c < 5000) begin
            @(negedge clk);
            c++;
        end
        if (latch_cnt < s + n) check("latch_timeout", latch_cnt, s + n);
    endtask

    task automatic do_load(input longint v, input bit ng, input logic [NUM_DIGITS-1:0] dt);
        wait_ready();
        @(negedge clk);
        data_bin = DATA_W'(v);
        neg      = ng;
        dot      = dt;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
        data_bin = DATA_W'($urandom);
        neg      = 1'($urandom);
        dot      = NUM_DIGITS'($urandom);
    endtask

    task automatic verify(input string name, input longint v, input bit ng,
                          input logic [NUM_DIGITS-1:0] dt);
        wait_ready();
        wait_frames(3);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            check($sformatf("%s_dig%0d", name, k), lat_seg[k], exp_seg(k, v, ng, dt, blank_lz));
        end
        check({name, "_ovf"}, ovf, exp_ovf(v, ng));
    endtask

    task automatic check_bright(input logic [BRIGHT_W-1:0] b);
        bright = b;
        wait_latches(2);
        check($sformatf("roe_low_b%0d", b), last_low, (int'(b) * SCAN_HOLD) >> BRIGHT_W);
    endtask

    longint bnd_v [5] = '{999999, 100000, 99999, 0, 1000000};
    bit     bnd_n [5] = '{0, 1, 1, 1, 0};

    initial begin
        longint v;
        bit     ng;
        logic [NUM_DIGITS-1:0] dt;
        int     n;

        repeat (3) @(negedge clk);
        check("rst_ds", ds, 0);
        check("rst_shcp", shcp, 0);
        check("rst_stcp", stcp, 0);
        check("rst_roe", roe, 1);
        check("rst_ready", ready, 1);
        check("rst_ovf", ovf, 0);
        rstn = 1'b1;

        blank_lz = 1'b1;
        do_load(123456, 0, 6'b000100);
        verify("t1", 123456, 0, 6'b000100);

        do_load(42, 1, 6'b000000);
        verify("t2_blank", 42, 1, 6'b000000);
        blank_lz = 1'b0;
        verify("t2_noblank", 42, 1, 6'b000000);
        blank_lz = 1'b1;

        do_load(999999, 1, 6'b100001);
        verify("t3_ovf", 999999, 1, 6'b100001);
        do_load(7, 0, 6'b000000);
        verify("t3_clear", 7, 0, 6'b000000);

        wait_ready();
        @(negedge clk);
        data_bin = DATA_W'(31415);
        neg      = 1'b0;
        dot      = 6'b000010;
        load     = 1'b1;
        @(negedge clk);
        data_bin = DATA_W'(271828);
        neg      = 1'b1;
        dot      = 6'b111111;
        n = 0;
        while (!ready && n < 100) begin
            n++;
            @(negedge clk);
            if (n == 3) load = 1'b0;
        end
        load = 1'b0;
        check("t4_ready_low", n, DATA_W);
        verify("t4", 31415, 0, 6'b000010);

        check_bright(0);
        check_bright(0);
        check_bright(8);
        check_bright(15);
        check_bright(BRIGHT_W'($urandom_range(1, 14)));
        bright = '1;

        for (int i = 0; i < 5; i++) begin
            blank_lz = 1'($urandom);
            dt = NUM_DIGITS'($urandom);
            do_load(bnd_v[i], bnd_n[i], dt);
            verify($sformatf("bnd%0d", i), bnd_v[i], bnd_n[i], dt);
        end

        for (int i = 0; i < 6; i++) begin
            case ($urandom_range(0, 3))
                0: v = $urandom_range(0, 9);
                1: v = $urandom_range(0, 99999);
                2: v = $urandom_range(0, 999999);
                default: v = $urandom_range(0, (1 << DATA_W) - 1);
            endcase
            ng       = 1'($urandom);
            dt       = NUM_DIGITS'($urandom);
            blank_lz = 1'($urandom);
            do_load(v, ng, dt);
            verify($sformatf("rnd%0d", i), v, ng, dt);
        end

        blank_lz = 1'b0;
        n = 0;
        while (sh_bits != 9 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sh_bits != 9) check("t6_reach_bit9", sh_bits, 9);
        rstn = 1'b0;
        @(negedge clk);
        check("t6_ds", ds, 0);
        check("t6_shcp", shcp, 0);
        check("t6_stcp", stcp, 0);
        check("t6_roe", roe, 1);
        check("t6_ready", ready, 1);
        rstn = 1'b1;
        verify("t6", 0, 0, 6'b000000);

        check("protocol", proto_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
